// File: rtl/zion_basic_circuit_lib_pkg.sv
// rtl/zion_basic_circuit_lib_pkg.sv - shared types for the basic circuit library
package zion_basic_circuit_lib_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/zion_basic_circuit_lib_clr_en_dff.sv
// rtl/zion_basic_circuit_lib_clr_en_dff.sv - data register with async reset, sync clear and load enable
module zion_basic_circuit_lib_clr_en_dff #(
    parameter int                WIDTH    = 8,
    parameter logic [WIDTH-1:0]  INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    logic [WIDTH-1:0] r_dat;

    // Clear wins over load so a flush cycle never captures a new beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dat <= INI_DATA;
        end else if (i_clr) begin
            r_dat <= INI_DATA;
        end else if (i_en) begin
            r_dat <= i_dat;
        end
    end

    assign o_dat = r_dat;

endmodule

// File: rtl/zion_basic_circuit_lib_clr_skid_buf.sv
// rtl/zion_basic_circuit_lib_clr_skid_buf.sv - two-entry flushable skid buffer; ZION_SKID_BUF_STALL_CNT_EN adds a stall counter
module zion_basic_circuit_lib_clr_skid_buf
    import zion_basic_circuit_lib_pkg::*;
#(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  INI_DATA  = '0,
    parameter int                CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iClr,
    input  logic                 iVld,
    output logic                 oRdy,
    input  logic [WIDTH-1:0]     iDat,
    output logic                 oVld,
    input  logic                 iRdy,
    output logic [WIDTH-1:0]     oDat,
    output logic [CNT_WIDTH-1:0] oStallCnt
);

    if (WIDTH < 1) begin : g_bad_width
        $error("zion_basic_circuit_lib_clr_skid_buf: WIDTH must be >= 1");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("zion_basic_circuit_lib_clr_skid_buf: CNT_WIDTH must be >= 1");
    end

    skid_state_e      r_state;
    skid_state_e      w_nxt_state;
    logic             r_ordy;
    logic             r_ovld;
    logic             w_acc;
    logic             w_dlv;
    logic             w_main_en;
    logic             w_skid_en;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_main_q;
    logic [WIDTH-1:0] w_skid_q;

    assign w_acc = iVld & r_ordy;
    assign w_dlv = r_ovld & iRdy;

    always_comb begin
        w_nxt_state = r_state;
        w_main_en   = 1'b0;
        w_skid_en   = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_acc) begin
                    w_nxt_state = ONE;
                    w_main_en   = 1'b1;
                end
            end
            ONE: begin
                if (w_acc && w_dlv) begin
                    w_main_en   = 1'b1;
                end else if (w_acc) begin
                    w_nxt_state = FULL;
                    w_skid_en   = 1'b1;
                end else if (w_dlv) begin
                    w_nxt_state = EMPTY;
                end
            end
            FULL: begin
                if (w_dlv) begin
                    w_nxt_state = ONE;
                    w_main_en   = 1'b1;
                end
            end
            default: begin
                w_nxt_state = EMPTY;
            end
        endcase
        if (iClr) begin
            w_nxt_state = EMPTY;
        end
    end

    // Only the FULL->ONE move refills main from skid; every other load takes the upstream beat.
    assign w_main_d = (r_state == FULL) ? w_skid_q : iDat;

    // Handshake flags are registered from the next state so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EMPTY;
            r_ordy  <= 1'b1;
            r_ovld  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_ordy  <= (w_nxt_state != FULL);
            r_ovld  <= (w_nxt_state != EMPTY);
        end
    end

    zion_basic_circuit_lib_clr_en_dff #(
        .WIDTH    (WIDTH),
        .INI_DATA (INI_DATA)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .i_clr (iClr),
        .i_en  (w_main_en),
        .i_dat (w_main_d),
        .o_dat (w_main_q)
    );

    zion_basic_circuit_lib_clr_en_dff #(
        .WIDTH    (WIDTH),
        .INI_DATA (INI_DATA)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .i_clr (iClr),
        .i_en  (w_skid_en),
        .i_dat (iDat),
        .o_dat (w_skid_q)
    );

    assign oRdy = r_ordy;
    assign oVld = r_ovld;
    assign oDat = w_main_q;

`ifdef ZION_SKID_BUF_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    // Saturating, and deliberately immune to iClr so flushes do not hide stall history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (r_ovld && !iRdy && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign oStallCnt = r_stall_cnt;
`else
    assign oStallCnt = '0;
`endif

endmodule
